// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: shared types and default parameter values for the burst RAM.
//   state_e      - controller state encoding
//   Def*         - default values for the burst_ram parameters
package burst_ram_pkg;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefBurstLen = 8;
  localparam int unsigned DefRdLat    = 2;
  localparam int unsigned DefWrLat    = 8;
  localparam int unsigned DefWrap     = 1;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrWait,
    StWrAck,
    StRdWait,
    StRdBurst
  } state_e;

endpackage

// File: rtl/burst_ram_if.sv
// burst_ram_if: request / write-beat / response bundle for burst_ram.
//   master: drives avalid, rnw, addr, wvalid, wdata; observes wready, busy, ack, rdata
//   slave : the RAM side, the reverse directions
interface burst_ram_if
  import burst_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) ();

  logic              avalid;
  logic              rnw;
  logic [ADDR_W-1:0] addr;
  logic              wvalid;
  logic [DATA_W-1:0] wdata;
  logic              wready;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output avalid, rnw, addr, wvalid, wdata,
    input  wready, busy, ack, rdata
  );

  modport slave (
    input  avalid, rnw, addr, wvalid, wdata,
    output wready, busy, ack, rdata
  );

endinterface

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: captures the request address and produces the beat address sequence.
//   load_i      - capture addr_i as block base + start offset, clear the beat counter
//   adv_i       - advance to the next beat
//   beat_addr_o - {base, (off + k) mod BURST_LEN} for the current beat k
//   last_o      - current beat is the final one (k == BURST_LEN-1)
//   done_o      - all BURST_LEN beats have been consumed
module burst_addr_gen
  import burst_ram_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned BURST_LEN = DefBurstLen,
  parameter int unsigned WRAP      = DefWrap
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] beat_addr_o,
  output logic              last_o,
  output logic              done_o
);

  localparam int unsigned       OffW    = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(BURST_LEN - 1);
  localparam logic [OffW:0]     LastCnt = (OffW + 1)'(BURST_LEN - 1);
  localparam logic [OffW:0]     DoneCnt = (OffW + 1)'(BURST_LEN);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [OffW-1:0]   off_q, off_d;
  // One extra bit so "all beats consumed" is distinguishable from beat 0.
  logic [OffW:0]     cnt_q, cnt_d;
  logic [OffW-1:0]   off_sum;

  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      base_d = addr_i & ~OffMask;
      off_d  = (WRAP != 0) ? addr_i[OffW-1:0] : '0;
      cnt_d  = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
      cnt_q  <= cnt_d;
    end
  end

  // Offset sum is OffW bits wide, so it wraps inside the block; base never moves.
  assign off_sum     = off_q + cnt_q[OffW-1:0];
  assign beat_addr_o = base_q | ADDR_W'(off_sum);
  assign last_o      = (cnt_q == LastCnt);
  assign done_o      = (cnt_q == DoneCnt);

endmodule

// File: rtl/burst_ram.sv
// burst_ram: single-port RAM with fixed-length read/write bursts and wrap addressing.
//   clk, rst_n - clock, asynchronous active-low reset (memory contents survive reset)
//   bus        - burst_ram_if slave: request (avalid/rnw/addr), write beats (wvalid/wdata/
//                wready), status/response (busy/ack/rdata)
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned BURST_LEN = DefBurstLen,
  parameter int unsigned RD_LAT    = DefRdLat,
  parameter int unsigned WR_LAT    = DefWrLat,
  parameter int unsigned WRAP      = DefWrap
) (
  input logic        clk,
  input logic        rst_n,
  burst_ram_if.slave bus
);

  localparam int unsigned    Depth     = 2 ** ADDR_W;
  localparam int unsigned    LatMax    = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned    LatW      = $clog2(LatMax + 1);
  localparam logic [LatW-1:0] RdLatLast = LatW'(RD_LAT - 1);
  localparam logic [LatW-1:0] WrLatLast = LatW'(WR_LAT - 1);

  state_e            state_q;
  logic [LatW-1:0]   lat_q;
  logic              ack_q;
  logic              wready_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [Depth];

  logic              accept;
  logic              wr_beat;
  logic              rd_issue;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_last;
  logic              beat_done;

  assign accept  = (state_q == StIdle) && bus.avalid;
  assign wr_beat = (state_q == StWrData) && bus.wvalid;
  // Beat 0 is fetched on the final latency edge so ack and rdata rise together.
  assign rd_issue = ((state_q == StRdWait) && (lat_q == RdLatLast)) ||
                    ((state_q == StRdBurst) && !beat_done);

  burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .WRAP      (WRAP)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .addr_i      (bus.addr),
    .adv_i       (wr_beat || rd_issue),
    .beat_addr_o (beat_addr),
    .last_o      (beat_last),
    .done_o      (beat_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lat_q    <= '0;
      ack_q    <= 1'b0;
      wready_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (rd_issue) begin
        rdata_q <= mem_q[beat_addr];
      end
      unique case (state_q)
        StIdle: begin
          if (bus.avalid) begin
            lat_q <= '0;
            if (bus.rnw) begin
              state_q <= StRdWait;
            end else begin
              state_q  <= StWrData;
              wready_q <= 1'b1;
            end
          end
        end
        StWrData: begin
          if (bus.wvalid && beat_last) begin
            wready_q <= 1'b0;
            lat_q    <= '0;
            state_q  <= StWrWait;
          end
        end
        StWrWait: begin
          if (lat_q == WrLatLast) begin
            ack_q   <= 1'b1;
            state_q <= StWrAck;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StWrAck: begin
          ack_q   <= 1'b0;
          state_q <= StIdle;
        end
        StRdWait: begin
          if (lat_q == RdLatLast) begin
            ack_q   <= 1'b1;
            state_q <= StRdBurst;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StRdBurst: begin
          if (beat_done) begin
            ack_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage has no reset so an aborted burst keeps the beats it already wrote.
  always_ff @(posedge clk) begin
    if (wr_beat) begin
      mem_q[beat_addr] <= bus.wdata;
    end
  end

`ifndef SYNTHESIS
  initial begin
    for (int i = 0; i < Depth; i++) begin
      mem_q[i] <= DATA_W'(i);
    end
  end
`endif

  assign bus.wready = wready_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.ack    = ack_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: three burst_ram instances (default, WRAP=0, RD_LAT=1/BURST_LEN=4/DATA_W=16)
// checked against a per-instance array model of memory contents and burst timing.
module tb_burst_ram;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  burst_ram_if #(.DATA_W(8),  .ADDR_W(8)) bus0 ();
  burst_ram_if #(.DATA_W(8),  .ADDR_W(8)) bus1 ();
  burst_ram_if #(.DATA_W(16), .ADDR_W(8)) bus2 ();

  burst_ram #(.DATA_W(8), .ADDR_W(8), .BURST_LEN(8), .RD_LAT(2), .WR_LAT(8), .WRAP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  burst_ram #(.DATA_W(8), .ADDR_W(8), .BURST_LEN(8), .RD_LAT(2), .WR_LAT(8), .WRAP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  burst_ram #(.DATA_W(16), .ADDR_W(8), .BURST_LEN(4), .RD_LAT(1), .WR_LAT(8), .WRAP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // Per-instance configuration, indexed by instance number.
  int unsigned bl     [3] = '{8, 8, 4};
  int unsigned rd_lat [3] = '{2, 2, 1};
  int unsigned wr_lat [3] = '{8, 8, 8};
  int unsigned wrap   [3] = '{1, 0, 1};
  logic [15:0] dmask  [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};

  logic        avalid [3];
  logic        rnw    [3];
  logic [7:0]  addr   [3];
  logic        wvalid [3];
  logic [15:0] wdata  [3];
  logic        ack_o    [3];
  logic        busy_o   [3];
  logic        wready_o [3];
  logic [15:0] rdata_o  [3];

  assign bus0.avalid = avalid[0];
  assign bus0.rnw    = rnw[0];
  assign bus0.addr   = addr[0];
  assign bus0.wvalid = wvalid[0];
  assign bus0.wdata  = wdata[0][7:0];
  assign bus1.avalid = avalid[1];
  assign bus1.rnw    = rnw[1];
  assign bus1.addr   = addr[1];
  assign bus1.wvalid = wvalid[1];
  assign bus1.wdata  = wdata[1][7:0];
  assign bus2.avalid = avalid[2];
  assign bus2.rnw    = rnw[2];
  assign bus2.addr   = addr[2];
  assign bus2.wvalid = wvalid[2];
  assign bus2.wdata  = wdata[2];

  assign ack_o[0]    = bus0.ack;
  assign busy_o[0]   = bus0.busy;
  assign wready_o[0] = bus0.wready;
  assign rdata_o[0]  = {8'h00, bus0.rdata};
  assign ack_o[1]    = bus1.ack;
  assign busy_o[1]   = bus1.busy;
  assign wready_o[1] = bus1.wready;
  assign rdata_o[1]  = {8'h00, bus1.rdata};
  assign ack_o[2]    = bus2.ack;
  assign busy_o[2]   = bus2.busy;
  assign wready_o[2] = bus2.wready;
  assign rdata_o[2]  = bus2.rdata;

  // Reference memory contents for each instance.
  logic [15:0] model [3][256];

  int checks = 0;
  int errors = 0;

  // Beat k of a burst: the block base plus a start offset that wraps around the block.
  function automatic int beat_addr(int s, int a, int k);
    int base;
    int off;
    base = a - (a % int'(bl[s]));
    off  = (wrap[s] != 0) ? (a % int'(bl[s])) : 0;
    return base + ((off + k) % int'(bl[s]));
  endfunction

  task automatic rd_burst(int s, int a, bit keep);
    logic        exp_ack;
    logic        exp_busy;
    logic [15:0] exp_data;
    int          last;
    avalid[s] = 1'b1;
    rnw[s]    = 1'b1;
    addr[s]   = 8'(a);
    @(posedge clk); #1;
    if (!keep) avalid[s] = 1'b0;
    checks++;
    if (busy_o[s] !== 1'b1) begin
      errors++;
      $display("FAIL rd_accept_busy dut%0d addr=%02h got=%b want=1", s, a, busy_o[s]);
    end
    last = int'(rd_lat[s] + bl[s]);
    for (int e = 1; e <= last; e++) begin
      @(posedge clk); #1;
      exp_ack  = (e >= int'(rd_lat[s])) && (e < last);
      exp_busy = (e < last);
      checks++;
      if (ack_o[s] !== exp_ack) begin
        errors++;
        $display("FAIL rd_ack dut%0d addr=%02h edge=%0d got=%b want=%b", s, a, e, ack_o[s],
                 exp_ack);
      end
      checks++;
      if (busy_o[s] !== exp_busy) begin
        errors++;
        $display("FAIL rd_busy dut%0d addr=%02h edge=%0d got=%b want=%b", s, a, e, busy_o[s],
                 exp_busy);
      end
      if (exp_ack) begin
        exp_data = model[s][beat_addr(s, a, e - int'(rd_lat[s]))];
        checks++;
        if (rdata_o[s] !== exp_data) begin
          errors++;
          $display("FAIL rd_data dut%0d addr=%02h beat=%0d got=%04h want=%04h", s, a,
                   e - int'(rd_lat[s]), rdata_o[s], exp_data);
        end
      end
    end
  endtask

  // dbase < 0 selects random data; abort_at >= 0 asserts reset before that beat.
  task automatic wr_burst(int s, int a, int gap_at, int gap_len, int abort_at, int dbase);
    logic [15:0] d;
    avalid[s] = 1'b1;
    rnw[s]    = 1'b0;
    addr[s]   = 8'(a);
    @(posedge clk); #1;
    avalid[s] = 1'b0;
    checks++;
    if (wready_o[s] !== 1'b1 || busy_o[s] !== 1'b1) begin
      errors++;
      $display("FAIL wr_accept dut%0d addr=%02h got wready=%b busy=%b want 1/1", s, a,
               wready_o[s], busy_o[s]);
    end
    for (int k = 0; k < int'(bl[s]); k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          wvalid[s] = 1'b0;
          @(posedge clk); #1;
          checks++;
          if (wready_o[s] !== 1'b1 || ack_o[s] !== 1'b0) begin
            errors++;
            $display("FAIL wr_gap dut%0d beat=%0d got wready=%b ack=%b want 1/0", s, k,
                     wready_o[s], ack_o[s]);
          end
        end
      end
      if (k == abort_at) begin
        wvalid[s] = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (ack_o[s] !== 1'b0 || wready_o[s] !== 1'b0 || busy_o[s] !== 1'b0 ||
            rdata_o[s] !== 16'h0) begin
          errors++;
          $display("FAIL abort_outputs dut%0d got ack=%b wready=%b busy=%b rdata=%04h want 0",
                   s, ack_o[s], wready_o[s], busy_o[s], rdata_o[s]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int e = 0; e < int'(wr_lat[s]) + 3; e++) begin
          @(posedge clk); #1;
          checks++;
          if (ack_o[s] !== 1'b0 || busy_o[s] !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ack dut%0d edge=%0d got ack=%b busy=%b want 0/0", s, e,
                     ack_o[s], busy_o[s]);
          end
        end
        return;
      end
      d = (dbase < 0) ? 16'($urandom) : 16'(dbase + k);
      d = d & dmask[s];
      wvalid[s] = 1'b1;
      wdata[s]  = d;
      @(posedge clk); #1;
      wvalid[s] = 1'b0;
      model[s][beat_addr(s, a, k)] = d;
      checks++;
      if (wready_o[s] !== (k < int'(bl[s]) - 1)) begin
        errors++;
        $display("FAIL wr_wready dut%0d beat=%0d got=%b want=%b", s, k, wready_o[s],
                 (k < int'(bl[s]) - 1));
      end
    end
    for (int e = 1; e <= int'(wr_lat[s]); e++) begin
      @(posedge clk); #1;
      checks++;
      if (ack_o[s] !== (e == int'(wr_lat[s])) || busy_o[s] !== 1'b1) begin
        errors++;
        $display("FAIL wr_ack dut%0d edge=%0d got ack=%b busy=%b want %b/1", s, e, ack_o[s],
                 busy_o[s], (e == int'(wr_lat[s])));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ack_o[s] !== 1'b0 || busy_o[s] !== 1'b0) begin
      errors++;
      $display("FAIL wr_done dut%0d got ack=%b busy=%b want 0/0", s, ack_o[s], busy_o[s]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (ack_o[s] !== 1'b0 || wready_o[s] !== 1'b0 || busy_o[s] !== 1'b0 ||
          rdata_o[s] !== 16'h0) begin
        errors++;
        $display("FAIL reset dut%0d got ack=%b wready=%b busy=%b rdata=%04h want 0", s,
                 ack_o[s], wready_o[s], busy_o[s], rdata_o[s]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_read;
    rd_burst(0, 'h13, 1'b0);
    rd_burst(1, 'h13, 1'b0);
  endtask

  task automatic test_write_gap;
    wr_burst(0, 'h20, 4, 3, -1, 'hA0);
    rd_burst(0, 'h20, 1'b0);
  endtask

  task automatic test_back_to_back;
    rd_burst(0, 'h5B, 1'b1);
    rd_burst(0, 'h5B, 1'b0);
  endtask

  task automatic test_reset_abort;
    wr_burst(0, 'h40, -1, 0, 4, 'hB0);
    rd_burst(0, 'h40, 1'b0);
  endtask

  task automatic test_small_cfg;
    rd_burst(2, 'h9A, 1'b0);
    wr_burst(2, 'h35, 2, 2, -1, -1);
    rd_burst(2, 'h36, 1'b0);
  endtask

  task automatic test_random;
    int s;
    int a;
    int a2;
    for (int it = 0; it < 12; it++) begin
      s  = (it % 2 == 0) ? 0 : 2;
      a  = int'($urandom_range(0, 255));
      a2 = a - (a % int'(bl[s])) + int'($urandom_range(0, bl[s] - 1));
      if ($urandom_range(0, 2) != 0) begin
        wr_burst(s, a, int'($urandom_range(0, bl[s] - 1)), int'($urandom_range(0, 3)), -1, -1);
      end
      rd_burst(s, a2, 1'b0);
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      avalid[s] = 1'b0;
      rnw[s]    = 1'b0;
      addr[s]   = '0;
      wvalid[s] = 1'b0;
      wdata[s]  = '0;
      for (int i = 0; i < 256; i++) model[s][i] = 16'(i) & dmask[s];
    end
    test_reset();
    test_wrap_read();
    test_write_gap();
    test_back_to_back();
    test_reset_abort();
    test_small_cfg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 Parameter DATA_W, default 8: data beat width in bits.
REQ-002 Parameter ADDR_W, default 8: word address width; depth is 2**ADDR_W words.
REQ-003 Parameter BURST_LEN, default 8: beats per burst, a power of two, at least 2 and at most 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 2: edges from request accept to the first read beat, at least 1.
REQ-005 Parameter WR_LAT, default 8: edges from the last write beat to the write ack, at least 1.
REQ-006 Parameter WRAP, default 1: 1 means critical-word-first wrap within the aligned burst block; 0 means the burst starts at the aligned block base.
REQ-007 clk  in  1  sole clock; all logic is sampled on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 avalid  in  1  request valid.
REQ-010 rnw  in  1  1 = read burst, 0 = write burst; sampled with avalid.
REQ-011 addr  in  ADDR_W  request word address; sampled with avalid.
REQ-012 wvalid  in  1  write beat valid.
REQ-013 wdata  in  DATA_W  write beat data.
REQ-014 wready  out  1  registered; high while write beats are accepted.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 ack  out  1  registered; read: high on each valid beat; write: one-cycle completion pulse.
REQ-017 rdata  out  DATA_W  registered read beat data; valid when ack=1 during a read.

Function
REQ-018 The FSM SHALL have states IDLE, WR_DATA, WR_WAIT, WR_ACK, RD_WAIT and RD_BURST.
REQ-019 Accept: in IDLE, at an edge with avalid=1, the block SHALL capture rnw and addr and go to RD_WAIT (rnw=1) or WR_DATA (rnw=0).
REQ-020 avalid SHALL be ignored in every state except IDLE; no request is queued.
REQ-021 Beat address SHALL be {base, (off+k) mod BURST_LEN} for beat k=0..BURST_LEN-1, where base is addr with the low log2(BURST_LEN) bits cleared; off is addr's low bits if WRAP=1, else 0.
REQ-022 Write: in WR_DATA, wready=1; each edge with wvalid=1 SHALL store wdata at the next beat address.
REQ-023 Write: after the BURST_LEN-th beat, wready SHALL deassert and the FSM SHALL move to WR_WAIT.
REQ-024 Write: wvalid gaps SHALL stall beat counting without timeout.
REQ-025 Write: ack SHALL be registered high exactly WR_LAT edges after the last-beat edge, for one cycle (WR_ACK), and the FSM SHALL then return to IDLE.
REQ-026 Read: ack SHALL be registered high starting RD_LAT edges after the accept edge.
REQ-027 Read: ack SHALL stay high for exactly BURST_LEN consecutive cycles, with rdata = mem[beat address k] in beat k; the FSM SHALL then return to IDLE with ack=0.
REQ-028 A new request SHALL be accepted no earlier than the edge after ack falls; back-to-back bursts therefore have one idle cycle.
REQ-029 Address arithmetic SHALL be modulo BURST_LEN on the offset only; base never increments.
REQ-030 Memory SHALL be readable in the same burst it was written (no read-during-write hazard, since read and write never overlap).
REQ-031 Memory SHALL initialise in simulation to mem[i] = i mod 2**DATA_W.

Reset
REQ-032 While rst_n=0, state SHALL be IDLE, counters 0, and ack, wready, busy and rdata all 0.
REQ-033 Reset SHALL not clear memory contents.
REQ-034 Reset mid-burst SHALL abort the burst; write beats already stored SHALL remain stored; no ack SHALL follow the abort.

Structure
REQ-035 A shared package burst_ram_pkg SHALL hold the state enum and default parameter constants.
REQ-036 One sub-module, burst_addr_gen (base/offset capture, beat counter, wrap arithmetic), SHALL be used; the storage array SHALL be inline.

Verification
REQ-037 Defaults, read addr=0x13, WRAP=1 -> ack high at edges 2..9 after accept; rdata 0x13,14,15,16,17,10,11,12.
REQ-038 Write addr=0x20, wdata 0xA0..0xA7 with a 3-cycle wvalid gap after beat 3 -> ack pulse exactly 8 edges after the last beat; a following read of 0x20 returns 0xA0..0xA7.
REQ-039 WRAP=0, read addr=0x13 -> rdata 0x10..0x17 in order.
REQ-040 avalid held high through a read burst -> no second accept until one cycle after ack falls; busy high throughout each burst.
REQ-041 rst_n low after write beat 4 of addr=0x40, wdata 0xB0..0xB7 -> ack never rises and outputs are 0; read 0x40 returns 0xB0..0xB3 then 0x44..0x47.
REQ-042 RD_LAT=1, BURST_LEN=4, DATA_W=16 -> first ack 1 edge after accept, 4 beats, correct 16-bit data.
